// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, flag indices, saturation constants
// and the float-to-int stage-1 payload.
package fpu_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // Bit positions inside the {NV,DZ,OF,UF,NX} flag vector.
  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  localparam int unsigned FPU_TAG_W = 5;

  // 32-bit limits are kept sign-extended to 64 bits, matching W/WU results.
  localparam logic [63:0] INT32_MAX = 64'h0000_0000_7FFF_FFFF;
  localparam logic [63:0] INT32_MIN = 64'hFFFF_FFFF_8000_0000;
  localparam logic [63:0] INT64_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] INT64_MIN = 64'h8000_0000_0000_0000;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SUB,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

  typedef struct packed {
    logic [2:0] rm;
    logic       is_unsigned;
    logic       is_word;
  } cvt_ctl_t;

  typedef struct packed {
    logic                 sign;
    logic [63:0]          int_part;
    logic [2:0]           grs;
    fp_class_e            cls;
    logic                 too_large;
    cvt_ctl_t             ctl;
    logic [FPU_TAG_W-1:0] tag;
  } s1_payload_t;

endpackage

// File: rtl/fp_to_int_pipe_if.sv
// Handshake bundle for the float-to-int converter: operand side and result side.
interface fp_to_int_pipe_if #(
  parameter int unsigned EXP_W = 11,
  parameter int unsigned MAN_W = 52,
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
);

  logic                   in_valid;
  logic                   in_ready;
  logic [EXP_W+MAN_W:0]   in_op;
  logic [2:0]             in_rm;
  logic                   in_is_unsigned;
  logic                   in_is_word;
  logic [TAG_W-1:0]       in_tag;

  logic                   out_valid;
  logic                   out_ready;
  logic [XLEN-1:0]        out_result;
  logic [4:0]             out_flags;
  logic [TAG_W-1:0]       out_tag;

  modport master (
    output in_valid, in_op, in_rm, in_is_unsigned, in_is_word, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_flags, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_rm, in_is_unsigned, in_is_word, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_flags, out_tag
  );

endinterface

// File: rtl/fp_round_inc.sv
// Rounding-increment decision from rounding mode, sign, lsb and G/R/S.
// Purely combinational; shared by the converters and the FMA.
module fp_round_inc
  import fpu_pkg::*;
(
  input  logic [2:0] rm,
  input  logic       sign,
  input  logic       lsb,
  input  logic       g,
  input  logic       r,
  input  logic       s,
  output logic       inc
);

  logic inexact;

  always_comb begin
    inc     = 1'b0;
    inexact = g | r | s;
    case (rm)
      RM_RNE:  inc = g & (r | s | lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & inexact;
      RM_RUP:  inc = ~sign & inexact;
      RM_RMM:  inc = g;
      default: inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/fp_to_int_pipe.sv
// Two-stage IEEE-754 to integer converter (RISC-V FCVT.{W,WU,L,LU}).
// Stage 1 unpacks and aligns; stage 2 rounds, range-checks and saturates.
module fp_to_int_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W = 11,
  parameter int unsigned MAN_W = 52,
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  fp_to_int_pipe_if.slave io
);

  localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
  // Significand shifted left by up to 65 keeps every fraction bit for sticky.
  localparam int unsigned SH_W = MAN_W + 66;

  logic                     adv1;
  logic                     adv2;

  logic                     op_sign;
  logic [EXP_W-1:0]         op_exp;
  logic [MAN_W-1:0]         op_man;
  logic                     exp_zero;
  logic                     exp_ones;
  logic                     man_zero;
  logic [MAN_W:0]           sig;
  logic signed [EXP_W+1:0]  unb_exp;
  logic                     too_large;
  logic                     tiny;
  logic [6:0]               sh_amt;
  logic [SH_W-1:0]          aligned;
  fp_class_e                cls;
  s1_payload_t              s1_new;

  logic                     s1_valid_q, s1_valid_d;
  s1_payload_t              s1_q, s1_d;

  logic                     inc;
  logic [64:0]              mag;
  logic [64:0]              pos_lim;
  logic [64:0]              neg_lim;
  logic                     in_range;
  logic                     is_nan;
  logic                     invalid;
  logic                     sat_low;
  logic [63:0]              sat_val;
  logic [63:0]              signed_mag;
  logic [63:0]              cvt_val;
  logic [63:0]              result;
  logic [4:0]               flags;

  logic                     s2_valid_q, s2_valid_d;
  logic [XLEN-1:0]          out_result_q, out_result_d;
  logic [4:0]               out_flags_q, out_flags_d;
  logic [TAG_W-1:0]         out_tag_q, out_tag_d;

  // ---------------------------------------------------------------- stage 1
  always_comb begin
    op_sign  = io.in_op[EXP_W+MAN_W];
    op_exp   = io.in_op[MAN_W +: EXP_W];
    op_man   = io.in_op[MAN_W-1:0];
    exp_zero = (op_exp == '0);
    exp_ones = (op_exp == '1);
    man_zero = (op_man == '0);
    sig      = {~exp_zero, op_man};

    // Subnormals take the minimum normal exponent; either way e lands below -1.
    unb_exp   = $signed({2'b00, (exp_zero ? EXP_W'(1) : op_exp)})
              - $signed((EXP_W+2)'(BIAS));
    too_large = (unb_exp > $signed((EXP_W+2)'(63)));
    tiny      = unb_exp[EXP_W+1] && (unb_exp != '1);
    sh_amt    = 7'(unb_exp + $signed((EXP_W+2)'(2)));
    aligned   = SH_W'(sig) << sh_amt;

    if (exp_ones) begin
      cls = man_zero ? CLS_INF : CLS_NAN;
    end else if (exp_zero) begin
      cls = man_zero ? CLS_ZERO : CLS_SUB;
    end else begin
      cls = CLS_NORM;
    end

    s1_new                 = '0;
    s1_new.sign            = op_sign;
    s1_new.cls             = cls;
    s1_new.too_large       = too_large;
    s1_new.ctl.rm          = io.in_rm;
    s1_new.ctl.is_unsigned = io.in_is_unsigned;
    s1_new.ctl.is_word     = io.in_is_word;
    s1_new.tag             = FPU_TAG_W'(io.in_tag);
    if (tiny) begin
      s1_new.int_part = '0;
      s1_new.grs      = {2'b00, |sig};
    end else begin
      s1_new.int_part = aligned[MAN_W+2 +: 64];
      s1_new.grs      = {aligned[MAN_W+1], aligned[MAN_W], |aligned[MAN_W-1:0]};
    end
  end

  // ---------------------------------------------------------------- stage 2
  fp_round_inc u_round_inc (
    .rm   (s1_q.ctl.rm),
    .sign (s1_q.sign),
    .lsb  (s1_q.int_part[0]),
    .g    (s1_q.grs[2]),
    .r    (s1_q.grs[1]),
    .s    (s1_q.grs[0]),
    .inc  (inc)
  );

  always_comb begin
    mag     = {1'b0, s1_q.int_part} + {64'd0, inc};
    pos_lim = '0;
    neg_lim = '0;
    // Negative limits for unsigned are zero: only a rounded -0 converts cleanly.
    case ({s1_q.ctl.is_word, s1_q.ctl.is_unsigned})
      2'b10: begin
        pos_lim = 65'h0_7FFF_FFFF;
        neg_lim = 65'h0_8000_0000;
      end
      2'b11: begin
        pos_lim = 65'h0_FFFF_FFFF;
        neg_lim = '0;
      end
      2'b00: begin
        pos_lim = {2'b00, {63{1'b1}}};
        neg_lim = {2'b01, 63'd0};
      end
      default: begin
        pos_lim = {1'b0, {64{1'b1}}};
        neg_lim = '0;
      end
    endcase

    in_range = s1_q.sign ? (mag <= neg_lim) : (mag <= pos_lim);
    is_nan   = (s1_q.cls == CLS_NAN);
    invalid  = is_nan || (s1_q.cls == CLS_INF) || s1_q.too_large || !in_range;

    sat_low = s1_q.sign & ~is_nan;
    if (s1_q.ctl.is_unsigned) begin
      sat_val = sat_low ? '0 : '1;
    end else if (s1_q.ctl.is_word) begin
      sat_val = sat_low ? INT32_MIN : INT32_MAX;
    end else begin
      sat_val = sat_low ? INT64_MIN : INT64_MAX;
    end

    signed_mag = s1_q.sign ? (64'd0 - mag[63:0]) : mag[63:0];
    cvt_val    = s1_q.ctl.is_word ? {{32{signed_mag[31]}}, signed_mag[31:0]}
                                  : signed_mag;

    result         = invalid ? sat_val : cvt_val;
    flags          = '0;
    flags[FLAG_NV] = invalid;
    flags[FLAG_NX] = ~invalid & (|s1_q.grs);
  end

  // ---------------------------------------------------------------- control
  always_comb begin
    adv2 = ~s2_valid_q | io.out_ready;
    adv1 = ~s1_valid_q | adv2;

    s1_valid_d = adv1 ? io.in_valid : s1_valid_q;
    s1_d       = (adv1 && io.in_valid) ? s1_new : s1_q;

    s2_valid_d   = adv2 ? s1_valid_q : s2_valid_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;
    out_tag_d    = out_tag_q;
    if (adv2 && s1_valid_q) begin
      out_result_d = XLEN'(result);
      out_flags_d  = flags;
      out_tag_d    = TAG_W'(s1_q.tag);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_q         <= '0;
      s2_valid_q   <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
      out_tag_q    <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_q         <= s1_d;
      s2_valid_q   <= s2_valid_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
      out_tag_q    <= out_tag_d;
    end
  end

  assign io.in_ready   = adv1;
  assign io.out_valid  = s2_valid_q;
  assign io.out_result = out_result_q;
  assign io.out_flags  = out_flags_q;
  assign io.out_tag    = out_tag_q;

endmodule

// File: tb/tb_fp_to_int_pipe.sv
// Directed bench for fp_to_int_pipe: hand-derived expectations queued at issue
// and compared in order as results leave the pipe.
module tb_fp_to_int_pipe;
  import fpu_pkg::*;

  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_NX   = 5'b00001;
  localparam logic [4:0] F_NV   = 5'b10000;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  flg;
    logic [4:0]  tag;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   ncyc = 0;
  int   last_pop_cyc = 0;
  exp_t sb[$];

  fp_to_int_pipe_if #(.EXP_W(11), .MAN_W(52), .XLEN(64), .TAG_W(5)) io ();

  fp_to_int_pipe #(.EXP_W(11), .MAN_W(52), .XLEN(64), .TAG_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ncyc++;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Result monitor: every accepted output must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && io.out_valid && io.out_ready) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_res"}, io.out_result, e.res);
        chk({e.name, "_flags"}, 64'(io.out_flags), 64'(e.flg));
        chk({e.name, "_tag"}, 64'(io.out_tag), 64'(e.tag));
        last_pop_cyc = ncyc;
      end
    end
  end

  task automatic drive(input logic [63:0] op, input logic [2:0] rm,
                       input logic uns, input logic word, input logic [4:0] tag);
    io.in_valid       = 1'b1;
    io.in_op          = op;
    io.in_rm          = rm;
    io.in_is_unsigned = uns;
    io.in_is_word     = word;
    io.in_tag         = tag;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input string name, input logic [63:0] op, input logic [2:0] rm,
                      input logic uns, input logic word, input logic [4:0] tag,
                      input logic [63:0] er, input logic [4:0] ef, input bit push);
    int n;
    n = 0;
    drive(op, rm, uns, word, tag);
    @(negedge clk);
    while (!io.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_accept"}, 64'(io.in_ready), 64'd1);
    if (push) sb.push_back('{er, ef, tag, name});
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drained"}, 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst_n             = 1'b0;
    io.in_valid       = 1'b0;
    io.in_op          = '0;
    io.in_rm          = RM_RNE;
    io.in_is_unsigned = 1'b0;
    io.in_is_word     = 1'b0;
    io.in_tag         = '0;
    io.out_ready      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(io.out_valid), 64'd0);
    chk("rst_out_result", io.out_result, 64'd0);
    chk("rst_out_flags", 64'(io.out_flags), 64'd0);
    chk("rst_out_tag", 64'(io.out_tag), 64'd0);
    chk("rst_in_ready", 64'(io.in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single op: latency and tag echo.
    send("p3p5_rne_l", 64'h400C000000000000, RM_RNE, 0, 0, 5'd1, 64'd4, F_NX, 1);
    @(negedge clk);
    chk("lat_first_cycle", 64'(io.out_valid), 64'd0);
    @(negedge clk);
    chk("lat_second_cycle", 64'(io.out_valid), 64'd1);
    @(posedge clk);
    #1;

    // Back-to-back directed vectors.
    send("m2p5_rne_w", 64'hC004000000000000, RM_RNE, 0, 1, 5'd2, 64'hFFFFFFFFFFFFFFFE, F_NX, 1);
    send("m2p5_rmm_w", 64'hC004000000000000, RM_RMM, 0, 1, 5'd3, 64'hFFFFFFFFFFFFFFFD, F_NX, 1);
    send("m2p5_rtz_w", 64'hC004000000000000, RM_RTZ, 0, 1, 5'd4, 64'hFFFFFFFFFFFFFFFE, F_NX, 1);
    send("p2e63_l",    64'h43E0000000000000, RM_RNE, 0, 0, 5'd5, 64'h7FFFFFFFFFFFFFFF, F_NV, 1);
    send("p2e63_lu",   64'h43E0000000000000, RM_RNE, 1, 0, 5'd6, 64'h8000000000000000, F_NONE, 1);
    send("nan_wu",     64'h7FF8000000000000, RM_RNE, 1, 1, 5'd7, 64'hFFFFFFFFFFFFFFFF, F_NV, 1);
    send("nan_w",      64'h7FF8000000000000, RM_RNE, 0, 1, 5'd8, 64'h000000007FFFFFFF, F_NV, 1);
    send("m0p5_rtz_lu",64'hBFE0000000000000, RM_RTZ, 1, 0, 5'd9, 64'd0, F_NX, 1);
    send("m0p5_rdn_lu",64'hBFE0000000000000, RM_RDN, 1, 0, 5'd10, 64'd0, F_NV, 1);
    send("p2e31_w",    64'h41E0000000000000, RM_RNE, 0, 1, 5'd11, 64'h000000007FFFFFFF, F_NV, 1);
    send("p2e31_wu",   64'h41E0000000000000, RM_RNE, 1, 1, 5'd12, 64'hFFFFFFFF80000000, F_NONE, 1);
    send("m2e31_w",    64'hC1E0000000000000, RM_RNE, 0, 1, 5'd13, 64'hFFFFFFFF80000000, F_NONE, 1);
    send("zero_l",     64'h0000000000000000, RM_RNE, 0, 0, 5'd14, 64'd0, F_NONE, 1);
    send("p1p5_rup_l", 64'h3FF8000000000000, RM_RUP, 0, 0, 5'd15, 64'd2, F_NX, 1);
    send("m1p5_rup_l", 64'hBFF8000000000000, RM_RUP, 0, 0, 5'd16, 64'hFFFFFFFFFFFFFFFF, F_NX, 1);
    send("p2e64_lu",   64'h43F0000000000000, RM_RNE, 1, 0, 5'd17, 64'hFFFFFFFFFFFFFFFF, F_NV, 1);
    drain("vectors");

    // Backpressure: two accepts fill the pipe, then the input stalls.
    io.out_ready = 1'b0;
    drive(64'h3FF0000000000000, RM_RNE, 0, 1, 5'd20);
    @(negedge clk);
    chk("bp_acc1_ready", 64'(io.in_ready), 64'd1);
    sb.push_back('{64'd1, F_NONE, 5'd20, "bp_one_w"});
    @(posedge clk);
    #1;
    drive(64'hFFF0000000000000, RM_RNE, 0, 0, 5'd21);
    @(negedge clk);
    chk("bp_acc2_ready", 64'(io.in_ready), 64'd1);
    sb.push_back('{64'h8000000000000000, F_NV, 5'd21, "bp_minf_l"});
    @(posedge clk);
    #1;
    drive(64'h4004000000000000, RM_RNE, 0, 0, 5'd22);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_stall_ready", 64'(io.in_ready), 64'd0);
      chk("bp_stall_valid", 64'(io.out_valid), 64'd1);
      chk("bp_stall_res", io.out_result, 64'd1);
      chk("bp_stall_flags", 64'(io.out_flags), 64'(F_NONE));
      chk("bp_stall_tag", 64'(io.out_tag), 64'd20);
      @(posedge clk);
      #1;
    end
    io.out_ready = 1'b1;
    c0 = ncyc;
    send("bp_p2p5_rne_l", 64'h4004000000000000, RM_RNE, 0, 0, 5'd22, 64'd2, F_NX, 1);
    send("bp_subn_rup_l", 64'h0000000000000001, RM_RUP, 0, 0, 5'd23, 64'd1, F_NX, 1);
    drain("bp");
    chk("bp_drain_span", 64'(last_pop_cyc - c0), 64'd3);

    // Reset with two operations in flight.
    io.out_ready = 1'b0;
    send("flush_a", 64'h400C000000000000, RM_RNE, 0, 0, 5'd30, 64'd0, F_NONE, 0);
    send("flush_b", 64'h3FF0000000000000, RM_RNE, 0, 0, 5'd31, 64'd0, F_NONE, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(io.out_valid), 64'd0);
    chk("mid_rst_out_result", io.out_result, 64'd0);
    chk("mid_rst_out_flags", 64'(io.out_flags), 64'd0);
    chk("mid_rst_out_tag", 64'(io.out_tag), 64'd0);
    chk("mid_rst_in_ready", 64'(io.in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    io.out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 64'(io.out_valid), 64'd0);
    @(posedge clk);
    #1;
    send("post_rst_m2p5_rne_l", 64'hC004000000000000, RM_RNE, 0, 0, 5'd24,
         64'hFFFFFFFFFFFFFFFE, F_NX, 1);
    @(negedge clk);
    chk("post_rst_lat1", 64'(io.out_valid), 64'd0);
    @(negedge clk);
    chk("post_rst_lat2", 64'(io.out_valid), 64'd1);
    @(posedge clk);
    #1;
    drain("post_rst");
    repeat (3) @(negedge clk);
    chk("final_idle", 64'(io.out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
